// File: rtl/timer_mc_core.sv
// Multi-channel prescaled countdown timer with one-shot/periodic modes and a sticky expiry flag per channel.
// Optional feature macro: TIMER_MC_PERIODIC_EN enables the periodic reload path. Without it, every channel is one-shot.
module timer_mc_core #(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 32,
    parameter int PS_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH*PS_WIDTH-1:0] prescaler_value,
    input  logic [NUM_CH*WIDTH-1:0]    timer_value,
    input  logic [NUM_CH-1:0]          periodic,
    input  logic [NUM_CH-1:0]          start,
    input  logic [NUM_CH-1:0]          stop,
    input  logic [NUM_CH-1:0]          irq_clear,
    output logic [NUM_CH*WIDTH-1:0]    curr_timer,
    output logic [NUM_CH-1:0]          ready,
    output logic [NUM_CH-1:0]          expired,
    output logic                       irq
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESCALER = 2'd1,
        TIMER     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [PS_WIDTH-1:0] PS_ONE = PS_WIDTH'(1);
    localparam logic [WIDTH-1:0]    TM_ONE = WIDTH'(1);

`ifndef TIMER_MC_PERIODIC_EN
    logic unused_periodic;
    assign unused_periodic = ^periodic;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t              state_q, state_d;
        logic [PS_WIDTH-1:0] ps_q, ps_d, ps_in;
        logic [WIDTH-1:0]    tm_q, tm_d, tm_in;
        logic                ready_q, ready_d;
        logic                exp_q, exp_d, exp_set;

        assign ps_in = prescaler_value[i*PS_WIDTH +: PS_WIDTH];
        assign tm_in = timer_value[i*WIDTH +: WIDTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                ps_q    <= '0;
                tm_q    <= '0;
                ready_q <= 1'b1;
                exp_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ps_q    <= ps_d;
                tm_q    <= tm_d;
                ready_q <= ready_d;
                exp_q   <= exp_d;
            end
        end

        always_comb begin
            state_d = state_q;
            ps_d    = ps_q;
            tm_d    = tm_q;
            ready_d = ready_q;
            exp_set = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start[i]) begin
                        ps_d    = ps_in;
                        tm_d    = tm_in;
                        ready_d = 1'b0;
                        state_d = PRESCALER;
                    end
                end
                PRESCALER: begin
                    if (stop[i])            state_d = DONE;
                    else if (ps_q == '0)    state_d = TIMER;
                    else                    ps_d    = ps_q - PS_ONE;
                end
                TIMER: begin
                    if (stop[i]) begin
                        state_d = DONE;
                    end else if (tm_q != '0) begin
                        tm_d    = tm_q - TM_ONE;
                        ps_d    = ps_in;
                        state_d = PRESCALER;
                    end else begin
                        exp_set = 1'b1;
                        state_d = DONE;
`ifdef TIMER_MC_PERIODIC_EN
                        // Periodic restart keeps ready low and picks up the live load values.
                        if (periodic[i]) begin
                            ps_d    = ps_in;
                            tm_d    = tm_in;
                            state_d = PRESCALER;
                        end
`endif
                    end
                end
                DONE: begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A natural expiry beats a coincident clear.
            exp_d = exp_set | (exp_q & ~irq_clear[i]);
        end

        assign curr_timer[i*WIDTH +: WIDTH] = tm_q;
        assign ready[i]                     = ready_q;
        assign expired[i]                   = exp_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |expired;
    end

endmodule

// File: tb/tb_timer_mc_core.sv
// Scoreboard bench for timer_mc_core: directed scenarios push cycle-stamped expectations, a monitor compares them.
// Expectations for the periodic channel follow TIMER_MC_PERIODIC_EN, matching the build of the core.
module tb_timer_mc_core;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 16;
    localparam int PS_W   = 8;

    localparam int S_RDY = 0;
    localparam int S_EXP = 1;
    localparam int S_IRQ = 2;
    localparam int S_CT0 = 3;
    localparam int S_CT1 = 4;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_CH*PS_W-1:0]   prescaler_value = '0;
    logic [NUM_CH*WIDTH-1:0]  timer_value = '0;
    logic [NUM_CH-1:0]        periodic = '0;
    logic [NUM_CH-1:0]        start = '0;
    logic [NUM_CH-1:0]        stop = '0;
    logic [NUM_CH-1:0]        irq_clear = '0;
    logic [NUM_CH*WIDTH-1:0]  curr_timer;
    logic [NUM_CH-1:0]        ready;
    logic [NUM_CH-1:0]        expired;
    logic                     irq;

    timer_mc_core #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PS_WIDTH(PS_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .prescaler_value(prescaler_value), .timer_value(timer_value),
        .periodic(periodic), .start(start), .stop(stop), .irq_clear(irq_clear),
        .curr_timer(curr_timer), .ready(ready), .expired(expired), .irq(irq)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } item_t;
    item_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    base = 0;

    function automatic logic [31:0] get_sig(input int sig);
        case (sig)
            S_RDY:   return 32'(ready);
            S_EXP:   return 32'(expired);
            S_IRQ:   return 32'(irq);
            S_CT0:   return 32'(curr_timer[15:0]);
            default: return 32'(curr_timer[31:16]);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic push(input int k, input int sig, input logic [31:0] v, input string nm);
        item_t e;
        e.cyc  = base + k;
        e.sig  = sig;
        e.val  = v;
        e.name = $sformatf("%s@c%0d", nm, k);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check missed, now cycle %0d", exp_q[k].name, cyc);
                exp_q.delete(k);
            end else if (exp_q[k].cyc == cyc) begin
                chk(exp_q[k].name, get_sig(exp_q[k].sig), exp_q[k].val);
                exp_q.delete(k);
            end
        end
    end

    // driver tasks
    task automatic wait_to(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic set_vals(input int ch, input logic [7:0] p, input logic [15:0] t);
        prescaler_value[ch*PS_W +: PS_W] = p;
        timer_value[ch*WIDTH +: WIDTH]   = t;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = m;
        @(negedge clk);
        start = '0;
    endtask

    task automatic pulse_clear(input logic [1:0] m);
        irq_clear = m;
        @(negedge clk);
        irq_clear = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = cyc;
        push(1, S_RDY, 32'h3, "rst_ready");
        push(1, S_EXP, 32'h0, "rst_expired");
        push(1, S_IRQ, 32'h0, "rst_irq");
        push(1, S_CT0, 32'h0, "rst_ct0");
        push(1, S_CT1, 32'h0, "rst_ct1");
        wait_to(3);

        // ch0 P=0 T=0 one-shot, then clear
        base = cyc;
        set_vals(0, 8'd0, 16'd0);
        push(1, S_RDY, 32'h2, "s1_ready_fall");
        push(2, S_EXP, 32'h0, "s1_exp_early");
        push(3, S_EXP, 32'h1, "s1_exp_set");
        push(3, S_RDY, 32'h2, "s1_ready_done");
        push(3, S_IRQ, 32'h0, "s1_irq_lag");
        push(4, S_RDY, 32'h3, "s1_ready_rise");
        push(4, S_IRQ, 32'h1, "s1_irq_set");
        push(4, S_CT1, 32'h0, "s1_ct1_untouched");
        pulse_start(2'b01);
        wait_to(5);
        push(6, S_EXP, 32'h0, "s1_exp_clr");
        push(6, S_IRQ, 32'h1, "s1_irq_hold");
        push(7, S_IRQ, 32'h0, "s1_irq_clr");
        pulse_clear(2'b01);
        wait_to(8);

        // ch0 P=3 T=2 one-shot
        base = cyc;
        set_vals(0, 8'd3, 16'd2);
        push(1,  S_RDY, 32'h2, "s2_ready_fall");
        push(1,  S_CT0, 32'd2, "s2_ct_c1");
        push(5,  S_CT0, 32'd2, "s2_ct_c5");
        push(6,  S_CT0, 32'd1, "s2_ct_c6");
        push(10, S_CT0, 32'd1, "s2_ct_c10");
        push(11, S_CT0, 32'd0, "s2_ct_c11");
        push(15, S_EXP, 32'h0, "s2_exp_early");
        push(16, S_EXP, 32'h1, "s2_exp_set");
        push(16, S_RDY, 32'h2, "s2_ready_done");
        push(16, S_IRQ, 32'h0, "s2_irq_lag");
        push(17, S_RDY, 32'h3, "s2_ready_rise");
        push(17, S_IRQ, 32'h1, "s2_irq_set");
        pulse_start(2'b01);
        wait_to(18);
        push(19, S_EXP, 32'h0, "s2_exp_clr");
        push(19, S_IRQ, 32'h1, "s2_irq_hold");
        push(20, S_IRQ, 32'h0, "s2_irq_clr");
        pulse_clear(2'b01);
        wait_to(21);

        // ch1 P=1 T=1 with periodic requested, clears, then stop
        base = cyc;
        set_vals(1, 8'd1, 16'd1);
        periodic = 2'b10;
        push(1,  S_RDY, 32'h1, "s3_ready_fall");
        push(1,  S_CT1, 32'd1, "s3_ct_c1");
        push(4,  S_CT1, 32'd0, "s3_ct_c4");
        push(6,  S_EXP, 32'h0, "s3_exp_early");
        push(7,  S_EXP, 32'h2, "s3_exp_set");
        push(8,  S_IRQ, 32'h1, "s3_irq_set");
        push(9,  S_EXP, 32'h0, "s3_exp_clr");
        push(10, S_IRQ, 32'h0, "s3_irq_clr");
        push(10, S_CT1, 32'd0, "s3_ct_c10");
        push(12, S_EXP, 32'h0, "s3_exp_c12");
        push(15, S_EXP, 32'h0, "s3_exp_stopclr");
        push(16, S_RDY, 32'h3, "s3_ready_end");
        push(19, S_EXP, 32'h0, "s3_exp_c19");
        push(20, S_EXP, 32'h0, "s3_exp_c20");
`ifdef TIMER_MC_PERIODIC_EN
        push(7,  S_CT1, 32'd1, "s3_ct_reload");
        push(13, S_EXP, 32'h2, "s3_exp_reset");
        push(15, S_RDY, 32'h1, "s3_ready_run");
`else
        push(7,  S_CT1, 32'd0, "s3_ct_noreload");
        push(7,  S_RDY, 32'h1, "s3_ready_done");
        push(8,  S_RDY, 32'h3, "s3_ready_rise");
        push(13, S_EXP, 32'h0, "s3_exp_noreset");
`endif
        pulse_start(2'b10);
        wait_to(8);
        pulse_clear(2'b10);
        wait_to(14);
        stop = 2'b10;
        irq_clear = 2'b10;
        @(negedge clk);
        stop = '0;
        irq_clear = '0;
        periodic = '0;
        wait_to(21);

        // stop coincident with expiry on ch0
        base = cyc;
        set_vals(0, 8'd0, 16'd0);
        push(1, S_RDY, 32'h2, "s4_ready_fall");
        push(3, S_RDY, 32'h2, "s4_ready_done");
        push(3, S_EXP, 32'h0, "s4_exp_c3");
        push(4, S_EXP, 32'h0, "s4_exp_c4");
        push(4, S_RDY, 32'h3, "s4_ready_rise");
        push(5, S_IRQ, 32'h0, "s4_irq");
        pulse_start(2'b01);
        wait_to(2);
        stop = 2'b01;
        @(negedge clk);
        stop = '0;
        wait_to(6);

        // start while running ignored; clear coincident with expiry loses
        base = cyc;
        set_vals(0, 8'd2, 16'd1);
        push(1,  S_CT0, 32'd1, "s5_ct_c1");
        push(3,  S_CT0, 32'd1, "s5_ct_c3");
        push(4,  S_CT0, 32'd1, "s5_ct_c4");
        push(5,  S_CT0, 32'd0, "s5_ct_c5");
        push(8,  S_EXP, 32'h0, "s5_exp_early");
        push(9,  S_EXP, 32'h1, "s5_exp_setwins");
        push(9,  S_RDY, 32'h2, "s5_ready_done");
        push(10, S_EXP, 32'h1, "s5_exp_hold");
        push(10, S_RDY, 32'h3, "s5_ready_rise");
        push(10, S_IRQ, 32'h1, "s5_irq");
        pulse_start(2'b01);
        wait_to(2);
        set_vals(0, 8'd0, 16'd7);
        start = 2'b01;
        @(negedge clk);
        start = '0;
        set_vals(0, 8'd2, 16'd1);
        wait_to(8);
        pulse_clear(2'b01);
        wait_to(12);

        // reset mid-count on both channels (expired[0] still set)
        base = cyc;
        set_vals(0, 8'd5, 16'd3);
        set_vals(1, 8'd5, 16'd2);
        periodic = 2'b10;
        push(3, S_RDY, 32'h0, "s6_ready_run");
        push(3, S_EXP, 32'h1, "s6_exp_run");
        push(3, S_IRQ, 32'h1, "s6_irq_run");
        push(3, S_CT0, 32'd3, "s6_ct0_run");
        push(3, S_CT1, 32'd2, "s6_ct1_run");
        pulse_start(2'b11);
        wait_to(4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready), 32'h3);
        chk("async_rst_expired", 32'(expired), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_ct0", 32'(curr_timer[15:0]), 32'h0);
        chk("async_rst_ct1", 32'(curr_timer[31:16]), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        periodic = '0;
        @(negedge clk);

        // restart after reset behaves as from reset
        base = cyc;
        set_vals(0, 8'd0, 16'd0);
        push(1, S_RDY, 32'h2, "s7_ready_fall");
        push(1, S_IRQ, 32'h0, "s7_irq_c1");
        push(2, S_EXP, 32'h0, "s7_exp_early");
        push(3, S_EXP, 32'h1, "s7_exp_set");
        push(4, S_RDY, 32'h3, "s7_ready_rise");
        push(4, S_IRQ, 32'h1, "s7_irq_set");
        push(4, S_CT1, 32'h0, "s7_ct1_idle");
        pulse_start(2'b01);

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            bad++;
            $display("FAIL %s: never checked", exp_q[k].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
